mips_instr_decoder: RTL and testbench



---
 rtl/mips_instr_decoder_pkg.sv | 49 ++++
 rtl/mips_instr_decoder_if.sv | 37 +++
 rtl/mips_instr_decoder_instr_flag_decode.sv | 34 +++
 rtl/mips_instr_decoder.sv | 114 +++++++++++
 tb/tb_mips_instr_decoder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mips_instr_decoder_pkg.sv
// Shared encodings for the MIPS subset decoder: opcode/func values,
// ALU operation codes, Tnew codes and the one-hot flag bundle.
package mips_instr_decoder_pkg;

    // Opcode field values (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Function field values for R-type (instruction[5:0])
    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_JR   = 6'b001000;

    // ALU operation selected in the execute stage
    typedef enum logic [2:0] {
        ALU_ADDU = 3'd0,
        ALU_SUBU = 3'd1,
        ALU_OR   = 3'd2,
        ALU_LUI  = 3'd3
    } alu_ctr_t;

    // Cycles until a result is available to the hazard unit
    typedef enum logic [1:0] {
        T_PC  = 2'b00,
        T_ALU = 2'b01,
        T_DM  = 2'b10
    } tnew_t;

    // One-hot instruction flags; at most one bit is set
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
    } instr_flags_t;

endpackage

// File: rtl/mips_instr_decoder_if.sv
// Decoder bus: instruction fields and flush in, combinational flags and
// registered execute-stage controls out.
interface mips_instr_decoder_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       flush;
    logic       addu;
    logic       subu;
    logic       ori;
    logic       lui;
    logic       lw;
    logic       sw;
    logic       beq;
    logic       j;
    logic       jal;
    logic       jr;
    logic       nop;
    logic       illegal;
    logic [5:0] op_e;
    logic [5:0] func_e;
    logic       alu_src_imm_e;
    logic [2:0] alu_ctr_e;
    logic       reg_wr_e;
    logic [1:0] tnew_e;

    modport master (
        output op, func, flush,
        input  addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop, illegal,
        input  op_e, func_e, alu_src_imm_e, alu_ctr_e, reg_wr_e, tnew_e
    );

    modport slave (
        input  op, func, flush,
        output addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop, illegal,
        output op_e, func_e, alu_src_imm_e, alu_ctr_e, reg_wr_e, tnew_e
    );
endinterface

// File: rtl/mips_instr_decoder_instr_flag_decode.sv
// Pure combinational op/func to one-hot flag decoder. Unlisted encodings,
// including R-type with an unknown func, produce an all-zero flag set.
module instr_flag_decode
    import mips_instr_decoder_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   func,
    output instr_flags_t flags
);

    // Decode opcode, then func for R-type, into a single flag
    always_comb begin
        flags = '0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FUNC_ADDU: flags.addu = 1'b1;
                    FUNC_SUBU: flags.subu = 1'b1;
                    FUNC_JR:   flags.jr   = 1'b1;
                    default:   flags      = '0;
                endcase
            end
            OP_ORI:  flags.ori = 1'b1;
            OP_LUI:  flags.lui = 1'b1;
            OP_LW:   flags.lw  = 1'b1;
            OP_SW:   flags.sw  = 1'b1;
            OP_BEQ:  flags.beq = 1'b1;
            OP_J:    flags.j   = 1'b1;
            OP_JAL:  flags.jal = 1'b1;
            default: flags     = '0;
        endcase
    end

endmodule

// File: rtl/mips_instr_decoder.sv
// Instruction decoder at the ID/EX boundary: combinational flags for the
// current instruction plus registered execute-stage control and Tnew.
module mips_instr_decoder
    import mips_instr_decoder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    mips_instr_decoder_if.slave    bus
);

    instr_flags_t flags_d_s;
    instr_flags_t flags_e_s;
    logic         nop_s;
    logic         alu_src_imm_nxt_s;
    alu_ctr_t     alu_ctr_nxt_s;
    logic         reg_wr_nxt_s;
    tnew_t        tnew_s;

    logic [5:0]   op_e_r;
    logic [5:0]   func_e_r;
    logic         alu_src_imm_e_r;
    alu_ctr_t     alu_ctr_e_r;
    logic         reg_wr_e_r;

    instr_flag_decode u_dec_d (
        .op    (bus.op),
        .func  (bus.func),
        .flags (flags_d_s)
    );

    // Re-decode the captured instruction so Tnew follows op_e/func_e exactly
    instr_flag_decode u_dec_e (
        .op    (op_e_r),
        .func  (func_e_r),
        .flags (flags_e_s)
    );

    assign nop_s = (bus.op == 6'd0) && (bus.func == 6'd0);

    assign bus.addu    = flags_d_s.addu;
    assign bus.subu    = flags_d_s.subu;
    assign bus.ori     = flags_d_s.ori;
    assign bus.lui     = flags_d_s.lui;
    assign bus.lw      = flags_d_s.lw;
    assign bus.sw      = flags_d_s.sw;
    assign bus.beq     = flags_d_s.beq;
    assign bus.j       = flags_d_s.j;
    assign bus.jal     = flags_d_s.jal;
    assign bus.jr      = flags_d_s.jr;
    assign bus.nop     = nop_s;
    assign bus.illegal = ~(|flags_d_s) & ~nop_s;

    // Next execute-stage controls; illegal encodings fall through to ADDU with no write
    always_comb begin
        alu_src_imm_nxt_s = flags_d_s.ori | flags_d_s.lui | flags_d_s.lw | flags_d_s.sw;
        reg_wr_nxt_s      = flags_d_s.addu | flags_d_s.subu | flags_d_s.ori |
                            flags_d_s.lui  | flags_d_s.lw   | flags_d_s.jal;
        alu_ctr_nxt_s     = ALU_ADDU;
        if (flags_d_s.subu) begin
            alu_ctr_nxt_s = ALU_SUBU;
        end else if (flags_d_s.ori) begin
            alu_ctr_nxt_s = ALU_OR;
        end else if (flags_d_s.lui) begin
            alu_ctr_nxt_s = ALU_LUI;
        end else begin
            alu_ctr_nxt_s = ALU_ADDU;
        end
    end

    // E-stage registers: async clear, flush inserts an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_e_r          <= 6'd0;
            func_e_r        <= 6'd0;
            alu_src_imm_e_r <= 1'b0;
            alu_ctr_e_r     <= ALU_ADDU;
            reg_wr_e_r      <= 1'b0;
        end else if (bus.flush) begin
            op_e_r          <= 6'd0;
            func_e_r        <= 6'd0;
            alu_src_imm_e_r <= 1'b0;
            alu_ctr_e_r     <= ALU_ADDU;
            reg_wr_e_r      <= 1'b0;
        end else begin
            op_e_r          <= bus.op;
            func_e_r        <= bus.func;
            alu_src_imm_e_r <= alu_src_imm_nxt_s;
            alu_ctr_e_r     <= alu_ctr_nxt_s;
            reg_wr_e_r      <= reg_wr_nxt_s;
        end
    end

    // Tnew of the instruction now in E; branches, jumps and stores produce nothing late
    always_comb begin
        tnew_s = T_PC;
        case (1'b1)
            flags_e_s.addu, flags_e_s.subu,
            flags_e_s.ori,  flags_e_s.lui:  tnew_s = T_ALU;
            flags_e_s.lw:                   tnew_s = T_DM;
            flags_e_s.sw,   flags_e_s.beq,
            flags_e_s.j,    flags_e_s.jal,
            flags_e_s.jr:                   tnew_s = T_PC;
            default:                        tnew_s = T_PC;
        endcase
    end

    assign bus.op_e          = op_e_r;
    assign bus.func_e        = func_e_r;
    assign bus.alu_src_imm_e = alu_src_imm_e_r;
    assign bus.alu_ctr_e     = alu_ctr_e_r;
    assign bus.reg_wr_e      = reg_wr_e_r;
    assign bus.tnew_e        = tnew_s;

endmodule

// File: tb/tb_mips_instr_decoder.sv
// Directed bench for mips_instr_decoder with hand-computed expectations.
module tb_mips_instr_decoder;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mips_instr_decoder_if bus ();

    mips_instr_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: addu subu ori lui lw sw beq j jal jr
    function automatic logic [9:0] dut_flags();
        return {bus.addu, bus.subu, bus.ori, bus.lui, bus.lw,
                bus.sw, bus.beq, bus.j, bus.jal, bus.jr};
    endfunction

    function automatic logic [9:0] ref_flags(input logic [5:0] o, input logic [5:0] f);
        logic [9:0] r;
        r[9] = (o == 6'h00) && (f == 6'h21);
        r[8] = (o == 6'h00) && (f == 6'h23);
        r[7] = (o == 6'h0D);
        r[6] = (o == 6'h0F);
        r[5] = (o == 6'h23);
        r[4] = (o == 6'h2B);
        r[3] = (o == 6'h04);
        r[2] = (o == 6'h02);
        r[1] = (o == 6'h03);
        r[0] = (o == 6'h00) && (f == 6'h08);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic [5:0] f);
        @(negedge clk);
        bus.op   = o;
        bus.func = f;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_e(input string tag, input logic [5:0] op_x, input logic [5:0] fn_x,
                         input logic src_x, input logic [2:0] ctr_x,
                         input logic wr_x, input logic [1:0] tn_x);
        chk({tag, ".op_e"},   32'(bus.op_e),          32'(op_x));
        chk({tag, ".func_e"}, 32'(bus.func_e),        32'(fn_x));
        chk({tag, ".src"},    32'(bus.alu_src_imm_e), 32'(src_x));
        chk({tag, ".ctr"},    32'(bus.alu_ctr_e),     32'(ctr_x));
        chk({tag, ".wr"},     32'(bus.reg_wr_e),      32'(wr_x));
        chk({tag, ".tnew"},   32'(bus.tnew_e),        32'(tn_x));
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.op   = 6'h00;
        bus.func = 6'h00;
        bus.flush = 1'b0;

        // Reset state
        edge_wait();
        chk("rst.nop", 32'(bus.nop), 32'd1);
        chk("rst.illegal", 32'(bus.illegal), 32'd0);
        chk_e("rst", 6'h00, 6'h00, 1'b0, 3'd0, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // addu
        drive(6'h00, 6'h21);
        chk("addu.flags", 32'(dut_flags()), 32'(10'b1000000000));
        chk("addu.illegal", 32'(bus.illegal), 32'd0);
        edge_wait();
        chk_e("addu", 6'h00, 6'h21, 1'b0, 3'd0, 1'b1, 2'b01);

        // lw then sw
        drive(6'h23, 6'h00);
        chk("lw.flags", 32'(dut_flags()), 32'(10'b0000100000));
        edge_wait();
        chk_e("lw", 6'h23, 6'h00, 1'b1, 3'd0, 1'b1, 2'b10);
        drive(6'h2B, 6'h00);
        chk("sw.flags", 32'(dut_flags()), 32'(10'b0000010000));
        edge_wait();
        chk_e("sw", 6'h2B, 6'h00, 1'b1, 3'd0, 1'b0, 2'b00);

        // ori, lui, subu
        drive(6'h0D, 6'h00);
        edge_wait();
        chk_e("ori", 6'h0D, 6'h00, 1'b1, 3'd2, 1'b1, 2'b01);
        drive(6'h0F, 6'h15);
        edge_wait();
        chk_e("lui", 6'h0F, 6'h15, 1'b1, 3'd3, 1'b1, 2'b01);
        drive(6'h00, 6'h23);
        chk("subu.flags", 32'(dut_flags()), 32'(10'b0100000000));
        edge_wait();
        chk_e("subu", 6'h00, 6'h23, 1'b0, 3'd1, 1'b1, 2'b01);

        // beq with an addu-looking func must not raise addu
        drive(6'h04, 6'h21);
        chk("beq.flags", 32'(dut_flags()), 32'(10'b0000001000));
        edge_wait();
        chk_e("beq", 6'h04, 6'h21, 1'b0, 3'd0, 1'b0, 2'b00);

        // Illegal opcode and illegal R-type func
        drive(6'h3F, 6'h00);
        chk("illop.illegal", 32'(bus.illegal), 32'd1);
        edge_wait();
        chk_e("illop", 6'h3F, 6'h00, 1'b0, 3'd0, 1'b0, 2'b00);
        drive(6'h00, 6'h20);
        chk("illfn.illegal", 32'(bus.illegal), 32'd1);
        chk("illfn.flags", 32'(dut_flags()), 32'(10'b0000000000));

        // jal then flush bubble, then normal capture
        drive(6'h03, 6'h00);
        edge_wait();
        chk_e("jal", 6'h03, 6'h00, 1'b0, 3'd0, 1'b1, 2'b00);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush.flags", 32'(dut_flags()), 32'(10'b0000000010));
        edge_wait();
        chk_e("flush", 6'h00, 6'h00, 1'b0, 3'd0, 1'b0, 2'b00);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.op    = 6'h0D;
        bus.func  = 6'h00;
        edge_wait();
        chk_e("postflush", 6'h0D, 6'h00, 1'b1, 3'd2, 1'b1, 2'b01);

        // Asynchronous reset mid-cycle with lw held
        drive(6'h23, 6'h00);
        edge_wait();
        chk("prerst.tnew", 32'(bus.tnew_e), 32'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        chk_e("asyncrst", 6'h00, 6'h00, 1'b0, 3'd0, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        edge_wait();
        chk_e("rstrel", 6'h23, 6'h00, 1'b1, 3'd0, 1'b1, 2'b10);

        // Exhaustive combinational sweep
        for (int o = 0; o < 64; o++) begin
            for (int f = 0; f < 64; f++) begin
                logic [9:0] ef;
                logic       en;
                bus.op   = 6'(o);
                bus.func = 6'(f);
                #1;
                ef = ref_flags(6'(o), 6'(f));
                en = (o == 0) && (f == 0);
                chk($sformatf("sweep.flags op=%0h fn=%0h", o, f), 32'(dut_flags()), 32'(ef));
                chk($sformatf("sweep.nop op=%0h fn=%0h", o, f), 32'(bus.nop), 32'(en));
                chk($sformatf("sweep.onehot op=%0h fn=%0h", o, f),
                    32'($countones(dut_flags())) + 32'(bus.nop) + 32'(bus.illegal), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
